// File: rtl/ks24_adder.sv
// ks24_adder: 28-bit Kogge-Stone parallel-prefix adder, three register stages.
// Stage 1 forms bitwise propagate/generate and folds the carry-in into bit 0.
// Stage 2 holds the group (G,P) after spans 1, 2 and 4.
// Stage 3 finishes spans 8 and 16 and registers SUM/COUT.
// One operand pair is accepted every clock, with no handshake.
module ks24_adder (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [27:0] A,
  input  logic [27:0] B,
  input  logic        CIN,
  output logic [27:0] SUM,
  output logic        COUT
);

  // Stage-1 registers: bitwise propagate, generate with the carry-in folded in, and the carry-in.
  logic [27:0] p_s1;
  logic [27:0] g_s1;
  logic        cin_s1;

  // Stage-2 registers: group generate/propagate after three prefix levels, plus the bit propagate.
  logic [27:0] grp_g_s2;
  logic [27:0] grp_p_s2;
  logic [27:0] p_s2;
  logic        cin_s2;

  // Combinational prefix network.
  logic [27:0] bit_p;
  logic [27:0] bit_g;
  logic [27:0] g_fold;
  logic [27:0] g_l1, p_l1;
  logic [27:0] g_l2, p_l2;
  logic [27:0] g_l3, p_l3;
  logic [27:0] g_l4, p_l4;
  logic [27:0] g_l5;
  logic [27:0] carries;
  logic [27:0] sum_next;
  logic        cout_next;

  // Folding the carry-in into g0 makes G[i:0] the carry into bit i+1 directly.
  assign bit_p  = A ^ B;
  assign bit_g  = A & B;
  assign g_fold = {bit_g[27:1], bit_g[0] | (bit_p[0] & CIN)};

  // Each level combines node i with node i-span. For nodes below the span,
  // shifting in 0 for G and 1 for P leaves the node unchanged.
  assign g_l1 = g_s1 | (p_s1 & (g_s1 << 1));
  assign p_l1 = p_s1 & ((p_s1 << 1) | 28'h0000001);
  assign g_l2 = g_l1 | (p_l1 & (g_l1 << 2));
  assign p_l2 = p_l1 & ((p_l1 << 2) | 28'h0000003);
  assign g_l3 = g_l2 | (p_l2 & (g_l2 << 4));
  assign p_l3 = p_l2 & ((p_l2 << 4) | 28'h000000F);

  // The last two levels operate on the stage-2 registered groups.
  assign g_l4 = grp_g_s2 | (grp_p_s2 & (grp_g_s2 << 8));
  assign p_l4 = grp_p_s2 & ((grp_p_s2 << 8) | 28'h00000FF);
  assign g_l5 = g_l4 | (p_l4 & (g_l4 << 16));

  // Bit 0 gets the raw carry-in. Bit i gets the group generate of bits i-1..0.
  assign carries   = {g_l5[26:0], cin_s2};
  assign sum_next  = p_s2 ^ carries;
  assign cout_next = g_l5[27];

  // Stage 1: capture bitwise propagate/generate and the carry-in.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      p_s1   <= '0;
      g_s1   <= '0;
      cin_s1 <= 1'b0;
    end else begin
      p_s1   <= bit_p;
      g_s1   <= g_fold;
      cin_s1 <= CIN;
    end
  end

  // Stage 2: capture the groups after spans 1, 2 and 4, and pass along p and the carry-in.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      grp_g_s2 <= '0;
      grp_p_s2 <= '0;
      p_s2     <= '0;
      cin_s2   <= 1'b0;
    end else begin
      grp_g_s2 <= g_l3;
      grp_p_s2 <= p_l3;
      p_s2     <= p_s1;
      cin_s2   <= cin_s1;
    end
  end

  // Stage 3: register the finished sum and the carry out of bit 27.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      SUM  <= '0;
      COUT <= 1'b0;
    end else begin
      SUM  <= sum_next;
      COUT <= cout_next;
    end
  end

endmodule

// File: tb/tb_ks24_adder.sv
// tb_ks24_adder: drives directed and random operands into ks24_adder. Every
// output is compared with A+B+CIN computed arithmetically and delayed through
// a three-entry delay line that clears on reset.
module tb_ks24_adder;

  logic        CLK;
  logic        RST_N;
  logic [27:0] A;
  logic [27:0] B;
  logic        CIN;
  logic [27:0] SUM;
  logic        COUT;

  int checks = 0;
  int errors = 0;

  // Expected {COUT,SUM} for the last three accepted edges. Entry 2 is visible at the output.
  logic [28:0] model [3];

  ks24_adder dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .A    (A),
    .B    (B),
    .CIN  (CIN),
    .SUM  (SUM),
    .COUT (COUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare the DUT outputs with an expected sum/carry pair.
  task automatic checkOutput(input string tag, input logic [27:0] exp_sum, input logic exp_cout);
    checks++;
    assert ({COUT, SUM} === {exp_cout, exp_sum}) else begin
      errors++;
      $error("[TB] FAIL %s: got cout=%0b sum=%07h, expected cout=%0b sum=%07h",
             tag, COUT, SUM, exp_cout, exp_sum);
    end
  endtask

  // Drive one vector, clock it in, advance the model, then check just after the edge.
  task automatic applyStimulus(input logic rst_n, input logic [27:0] a, input logic [27:0] b,
                               input logic cin, input string tag);
    RST_N = rst_n;
    A     = a;
    B     = b;
    CIN   = cin;
    @(posedge CLK);
    if (!rst_n) begin
      model[0] = '0;
      model[1] = '0;
      model[2] = '0;
    end else begin
      model[2] = model[1];
      model[1] = model[0];
      model[0] = {1'b0, a} + {1'b0, b} + {28'd0, cin};
    end
    #1;
    checkOutput(tag, model[2][27:0], model[2][28]);
  endtask

  // Apply one vector, flush it with two idle vectors, then check against a hand-computed result.
  task automatic runDirected(input logic [27:0] a, input logic [27:0] b, input logic cin,
                             input logic [27:0] exp_sum, input logic exp_cout, input string tag);
    applyStimulus(1'b1, a, b, cin, tag);
    applyStimulus(1'b1, 28'd0, 28'd0, 1'b0, {tag, "_idle1"});
    applyStimulus(1'b1, 28'd0, 28'd0, 1'b0, {tag, "_idle2"});
    checkOutput({tag, "_literal"}, exp_sum, exp_cout);
  endtask

  initial begin
    RST_N = 1'b0;
    A     = '0;
    B     = '0;
    CIN   = 1'b0;

    // Reset held for two edges, then released with zero operands.
    applyStimulus(1'b0, 28'd0, 28'd0, 1'b0, "reset0");
    checkOutput("reset0_literal", 28'd0, 1'b0);
    applyStimulus(1'b0, 28'd0, 28'd0, 1'b0, "reset1");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 28'd0, 28'd0, 1'b0, "post_reset_zero");

    // Directed arithmetic cases, including carry ripple and full-width wrap.
    runDirected(28'h0000001, 28'h0000001, 1'b1, 28'h0000003, 1'b0, "small_cin");
    runDirected(28'h0FFFFFF, 28'h0FFFFFF, 1'b1, 28'h1FFFFFF, 1'b0, "ripple24");
    runDirected(28'h1234567, 28'h7654321, 1'b0, 28'h8888888, 1'b0, "mixed");
    runDirected(28'h8000000, 28'h7FFFFFF, 1'b0, 28'hFFFFFFF, 1'b0, "all_ones_no_cout");
    runDirected(28'hFFFFFFF, 28'h0000001, 1'b0, 28'h0000000, 1'b1, "full_chain");
    runDirected(28'hFFFFFFF, 28'hFFFFFFF, 1'b1, 28'hFFFFFFF, 1'b1, "max_operands");

    // Back-to-back random stream.
    for (int i = 0; i < 24; i++)
      applyStimulus(1'b1, 28'($urandom), 28'($urandom), 1'($urandom), "stream");

    // Reset mid-stream, with live operands on the inputs.
    applyStimulus(1'b0, 28'($urandom), 28'($urandom), 1'($urandom), "mid_reset");
    checkOutput("mid_reset_literal", 28'd0, 1'b0);

    // No pre-reset result may leak out after release.
    applyStimulus(1'b1, 28'($urandom), 28'($urandom), 1'($urandom), "release0");
    checkOutput("release0_literal", 28'd0, 1'b0);
    applyStimulus(1'b1, 28'($urandom), 28'($urandom), 1'($urandom), "release1");
    checkOutput("release1_literal", 28'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 28'($urandom), 28'($urandom), 1'($urandom), "post_release");
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 28'd0, 28'd0, 1'b0, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
